// File: rtl/snd_cmd_pkg.sv
// Shared definitions for the sound command queue: FSM state encoding and
// default timing constants.
package snd_cmd_pkg;

  localparam int unsigned DEFAULT_DEPTH_LOG2     = 32'd4;
  localparam logic [19:0] DEFAULT_GAP_CYCLES     = 20'd50000;
  localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd5000000;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] GAP      = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = IDLE,
    ST_WAIT_ACK = WAIT_ACK,
    ST_GAP      = GAP
  } state_t;

endpackage

// File: rtl/snd_cmd_queue_if.sv
// Command-queue bus: UART-side push handshake plus the sound CPU latch/IRQ
// side. The queue is the slave; the UART/CPU glue (or a bench) is the master.
interface snd_cmd_queue_if
  import snd_cmd_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);

  logic [7:0]          cmd_data;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                clear_irq;
  logic                flush;
  logic [7:0]          sound_latch;
  logic                irq;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                timeout;

  modport master (
    output cmd_data, cmd_valid, clear_irq, flush,
    input  cmd_ready, sound_latch, irq, level, overflow, timeout
  );

  modport slave (
    input  cmd_data, cmd_valid, clear_irq, flush,
    output cmd_ready, sound_latch, irq, level, overflow, timeout
  );

endinterface

// File: rtl/snd_cmd_fifo.sv
// Single-clock byte FIFO with registered pointers and occupancy, a flush that
// empties it in one cycle, and a combinational read of the head entry.
module snd_cmd_fifo
  import snd_cmd_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int                  DEPTH     = 32'd1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1'b1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == '0);
  assign level     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  // Flush wins over both ports so a same-cycle push is discarded.
  assign do_push_s = push & ~full & ~flush;
  assign do_pop_s  = pop & ~empty & ~flush;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/snd_cmd_queue.sv
// Sound command queue: buffers UART command bytes and hands them to the sound
// CPU one at a time via latch + IRQ, with acknowledge and inter-command gap.
// Optional acknowledge watchdog is compiled in with SND_CMD_TIMEOUT_EN.
module snd_cmd_queue
  import snd_cmd_pkg::*;
#(
  parameter int          DEPTH_LOG2     = DEFAULT_DEPTH_LOG2,
  parameter logic [19:0] GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic            clk,
  input logic            rst,
  snd_cmd_queue_if.slave bus
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                irq_r;
  logic                irq_nxt_s;
  logic [7:0]          latch_r;
  logic [19:0]         gap_cnt_r;
  logic [19:0]         gap_nxt_s;
  logic                clr_prev_r;
  logic                clr_rise_s;
  logic                overflow_r;
  logic                timeout_r;
  logic                pop_s;
  logic                set_timeout_s;
  logic                tmo_expired_s;
  logic [7:0]          fifo_rdata_s;
  logic [DEPTH_LOG2:0] fifo_level_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;

  snd_cmd_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .push  (bus.cmd_valid),
    .pop   (pop_s),
    .wdata (bus.cmd_data),
    .rdata (fifo_rdata_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign clr_rise_s      = bus.clear_irq & ~clr_prev_r;
  assign bus.cmd_ready   = ~fifo_full_s;
  assign bus.level       = fifo_level_s;
  assign bus.sound_latch = latch_r;
  assign bus.irq         = irq_r;
  assign bus.overflow    = overflow_r;
  assign bus.timeout     = timeout_r;

`ifdef SND_CMD_TIMEOUT_EN
  logic [23:0] tmo_cnt_r;

  // Acknowledge watchdog: counts cycles spent in WAIT_ACK, restarts elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 24'd0;
    end else if (bus.flush || (state_r != ST_WAIT_ACK) || clr_rise_s || tmo_expired_s) begin
      tmo_cnt_r <= 24'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 24'd1;
    end
  end

  assign tmo_expired_s = (state_r == ST_WAIT_ACK) && ((tmo_cnt_r + 24'd1) >= TIMEOUT_CYCLES);
`else
  // No watchdog: the parameter stays referenced so both builds share one interface.
  assign tmo_expired_s = 1'b0 & (TIMEOUT_CYCLES != 24'd0);
`endif

  // Clear-IRQ edge detector; tracks the level in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_prev_r <= 1'b0;
    end else begin
      clr_prev_r <= bus.clear_irq;
    end
  end

  // Issue / acknowledge / gap sequencing.
  always_comb begin
    state_nxt_s   = state_r;
    irq_nxt_s     = irq_r;
    gap_nxt_s     = gap_cnt_r;
    pop_s         = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && !bus.flush) begin
          pop_s       = 1'b1;
          irq_nxt_s   = 1'b1;
          state_nxt_s = ST_WAIT_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (clr_rise_s || tmo_expired_s) begin
          irq_nxt_s     = 1'b0;
          set_timeout_s = ~clr_rise_s;
          if (GAP_CYCLES == 20'd0) begin
            state_nxt_s = ST_IDLE;
            gap_nxt_s   = 20'd0;
          end else begin
            state_nxt_s = ST_GAP;
            gap_nxt_s   = GAP_CYCLES - 20'd1;
          end
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 20'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gap_nxt_s = gap_cnt_r - 20'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        irq_nxt_s   = 1'b0;
        gap_nxt_s   = 20'd0;
      end
    endcase
  end

  // Control registers; flush aborts the command but keeps the last latched byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      irq_r      <= 1'b0;
      latch_r    <= 8'h00;
      gap_cnt_r  <= 20'd0;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else if (bus.flush) begin
      state_r    <= ST_IDLE;
      irq_r      <= 1'b0;
      gap_cnt_r  <= 20'd0;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      irq_r      <= irq_nxt_s;
      gap_cnt_r  <= gap_nxt_s;
      overflow_r <= overflow_r | (bus.cmd_valid & fifo_full_s);
      timeout_r  <= timeout_r | set_timeout_s;
      if (pop_s) begin
        latch_r <= fifo_rdata_s;
      end
    end
  end

endmodule

// File: tb/tb_snd_cmd_queue.sv
// Directed bench for snd_cmd_queue: queue/timestamp reference model checked
// every cycle, plus hand-computed expectations along each scenario.
module tb_snd_cmd_queue;

  localparam int          DL     = 4;
  localparam int          DEPTH  = 16;
  localparam logic [19:0] GAP    = 20'd4;
  localparam int          GAP_I  = 4;
  localparam logic [23:0] TMO    = 24'd100;
  localparam int          TMO_I  = 100;
`ifdef SND_CMD_TIMEOUT_EN
  localparam bit          TMO_ON = 1'b1;
`else
  localparam bit          TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  snd_cmd_queue_if #(.DEPTH_LOG2(DL)) bus ();

  snd_cmd_queue #(
    .DEPTH_LOG2     (DL),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checkl(input string name, input logic [DL:0] act, input logic [DL:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: byte queue, pending flag and the earliest cycle a pop may happen.
  logic [7:0] mq[$];
  logic [7:0] m_latch    = 8'h00;
  logic       m_irq      = 1'b0;
  logic       m_ovf      = 1'b0;
  logic       m_tmo      = 1'b0;
  logic       m_wait     = 1'b0;
  logic       m_prev     = 1'b0;
  int         m_wait_cnt = 0;
  int         m_pop_from = 0;
  int         cyc        = 0;

  initial begin
    forever begin
      int   now;
      int   sz0;
      logic rise;
      @(posedge clk);
      now  = cyc;
      cyc  = cyc + 1;
      sz0  = mq.size();
      rise = bus.clear_irq & ~m_prev;
      if (rst) begin
        mq.delete();
        m_latch = 8'h00; m_irq = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
        m_wait = 1'b0; m_prev = 1'b0; m_pop_from = 0;
      end else begin
        m_prev = bus.clear_irq;
        if (bus.flush) begin
          mq.delete();
          m_irq = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_wait = 1'b0;
          m_pop_from = now + 1;
        end else begin
          if (m_wait) begin
            m_wait_cnt++;
            if (rise) begin
              m_irq = 1'b0; m_wait = 1'b0; m_pop_from = now + 1 + GAP_I;
            end else if (TMO_ON && m_wait_cnt == TMO_I) begin
              m_irq = 1'b0; m_wait = 1'b0; m_tmo = 1'b1; m_pop_from = now + 1 + GAP_I;
            end
          end else if (sz0 > 0 && now >= m_pop_from) begin
            m_latch = mq.pop_front();
            m_irq = 1'b1; m_wait = 1'b1; m_wait_cnt = 0;
          end
          if (bus.cmd_valid) begin
            if (sz0 < DEPTH) mq.push_back(bus.cmd_data);
            else m_ovf = 1'b1;
          end
        end
      end
      #1;
      checkb("model irq", bus.irq, m_irq);
      check8("model sound_latch", bus.sound_latch, m_latch);
      checkl("model level", bus.level, (DL + 1)'(mq.size()));
      checkb("model cmd_ready", bus.cmd_ready, mq.size() < DEPTH);
      checkb("model overflow", bus.overflow, m_ovf);
      checkb("model timeout", bus.timeout, m_tmo);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.clear_irq = 1'b1;
    step();
    bus.clear_irq = 1'b0;
    checkb("ack irq low", bus.irq, 1'b0);
  endtask

  // Acknowledge, then the next byte must appear exactly GAP+1 cycles later.
  task automatic ack_expect(input logic [7:0] exp_byte, input logic [DL:0] exp_level);
    ack_pulse();
    repeat (GAP_I) step();
    checkb("gap irq still low", bus.irq, 1'b0);
    step();
    checkb("issue irq", bus.irq, 1'b1);
    check8("issue byte", bus.sound_latch, exp_byte);
    checkl("issue level", bus.level, exp_level);
  endtask

  initial begin
    int hi;
    int lo;
    bus.cmd_data  = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.clear_irq = 1'b0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    checkb("reset irq", bus.irq, 1'b0);
    check8("reset latch", bus.sound_latch, 8'h00);
    checkl("reset level", bus.level, 5'd0);
    checkb("reset cmd_ready", bus.cmd_ready, 1'b1);
    checkb("reset overflow", bus.overflow, 1'b0);
    checkb("reset timeout", bus.timeout, 1'b0);

    // Single byte: visible two cycles after the push, dropped one after ack.
    push(8'h5A);
    checkl("single level", bus.level, 5'd1);
    checkb("single irq early", bus.irq, 1'b0);
    step();
    checkb("single irq", bus.irq, 1'b1);
    check8("single byte", bus.sound_latch, 8'h5A);
    ack_pulse();
    check8("latch held after ack", bus.sound_latch, 8'h5A);
    repeat (8) step();

    // Three back-to-back bytes issued in order with the gap enforced.
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'h01; step();
    bus.cmd_data = 8'h02; step();
    bus.cmd_data = 8'h03; step();
    bus.cmd_valid = 1'b0;
    check8("burst first", bus.sound_latch, 8'h01);
    checkl("burst level", bus.level, 5'd2);
    ack_expect(8'h02, 5'd1);
    ack_expect(8'h03, 5'd0);
    ack_pulse();
    repeat (8) step();

    // Fill to 16 queued (plus one issued), then offer one more while full.
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.cmd_data = 8'h10 + 8'(i);
      step();
    end
    checkb("full cmd_ready", bus.cmd_ready, 1'b0);
    checkl("full level", bus.level, 5'd16);
    bus.cmd_data = 8'hEE;
    step();
    bus.cmd_valid = 1'b0;
    checkb("overflow set", bus.overflow, 1'b1);
    checkl("overflow level", bus.level, 5'd16);
    check8("overflow head", bus.sound_latch, 8'h10);
    for (int i = 1; i <= 16; i++) begin
      ack_expect(8'h10 + 8'(i), 5'(16 - i));
    end
    ack_pulse();
    repeat (8) step();

    // clear_irq already high when the byte issues must not acknowledge it.
    bus.clear_irq = 1'b1;
    repeat (3) step();
    push(8'h77);
    step();
    checkb("held clr irq", bus.irq, 1'b1);
    repeat (4) step();
    checkb("held clr no ack", bus.irq, 1'b1);
    bus.clear_irq = 1'b0;
    step();
    checkb("clr fell no ack", bus.irq, 1'b1);
    ack_pulse();
    repeat (8) step();

    // Flush during WAIT_ACK with five bytes queued; same-cycle push discarded.
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_data = 8'h30 + 8'(i);
      step();
    end
    bus.cmd_valid = 1'b0;
    checkl("pre-flush level", bus.level, 5'd5);
    check8("pre-flush byte", bus.sound_latch, 8'h30);
    bus.flush = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'h99;
    step();
    bus.flush = 1'b0;
    bus.cmd_valid = 1'b0;
    checkb("flush irq", bus.irq, 1'b0);
    checkl("flush level", bus.level, 5'd0);
    check8("flush keeps latch", bus.sound_latch, 8'h30);
    checkb("flush clears overflow", bus.overflow, 1'b0);
    push(8'h42);
    checkl("post-flush level", bus.level, 5'd1);
    step();
    checkb("post-flush irq", bus.irq, 1'b1);
    check8("post-flush byte", bus.sound_latch, 8'h42);
    ack_pulse();
    repeat (8) step();

`ifdef SND_CMD_TIMEOUT_EN
    // Never acknowledge: irq must stay up exactly TIMEOUT cycles, then gap, then next byte.
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'hA1; step();
    bus.cmd_data = 8'hA2; step();
    bus.cmd_valid = 1'b0;
    check8("tmo first byte", bus.sound_latch, 8'hA1);
    hi = 0;
    while (bus.irq === 1'b1 && hi < 300) begin
      hi++;
      step();
    end
    checki("tmo irq high cycles", hi, 100);
    checkb("tmo flag", bus.timeout, 1'b1);
    lo = 0;
    while (bus.irq !== 1'b1 && lo < 50) begin
      lo++;
      step();
    end
    checki("tmo gap cycles", lo, GAP_I + 1);
    check8("tmo next byte", bus.sound_latch, 8'hA2);
    ack_pulse();
    checkb("tmo flag sticky", bus.timeout, 1'b1);
    repeat (8) step();
`endif

    // Reset mid-command drops queue, irq and latch.
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'h51; step();
    bus.cmd_data = 8'h52; step();
    bus.cmd_valid = 1'b0;
    checkb("pre-reset irq", bus.irq, 1'b1);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    checkb("mid reset irq", bus.irq, 1'b0);
    check8("mid reset latch", bus.sound_latch, 8'h00);
    checkl("mid reset level", bus.level, 5'd0);
    checkb("mid reset timeout", bus.timeout, 1'b0);
    push(8'hC3);
    step();
    checkb("after reset irq", bus.irq, 1'b1);
    check8("after reset byte", bus.sound_latch, 8'hC3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
